// File: rtl/button_conditioner.sv
// button_conditioner: five-channel push-button front end.
// Each raw button is synchronized and debounced. The four direction channels
// produce an initial move pulse on press, then auto-repeat while held. The fire
// channel produces exactly one pulse per press. The enable input gates the
// outputs only; synchronizers and debouncers keep tracking the buttons.
//
// Repeat FSM (one per direction channel)
//   state      | meaning
//   RPT_IDLE   | button released, or press not accepted while disabled
//   RPT_DELAY  | press pulse sent, counting toward first auto-repeat
//   RPT_REPEAT | auto-repeating at the repeat rate
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic raw_up,
    input  logic raw_down,
    input  logic raw_left,
    input  logic raw_right,
    input  logic raw_fire,
    output logic btn_up,
    output logic btn_down,
    output logic btn_left,
    output logic btn_right,
    output logic btn_fire
);

    // Channel index map: 0 up, 1 down, 2 left, 3 right, 4 fire.
    localparam int NUM_CH  = 5;
    localparam int NUM_DIR = 4;
    localparam int FIRE_CH = 4;

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    // Terminal counts: the count value seen on the edge that completes a period.
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] sync_meta;
    logic [NUM_CH-1:0] sync_out;
    logic [NUM_CH-1:0] db_level;
    logic [NUM_CH-1:0] press_evt;
    logic [NUM_CH-1:0] release_evt;
    logic [NUM_CH-1:0] pulse_next;

    assign raw_vec = {raw_fire, raw_right, raw_left, raw_down, raw_up};

    // Two-flop synchronizer for every raw button level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= raw_vec;
            sync_out  <= sync_meta;
        end
    end

    // Debouncer per channel. The press/release event is flagged combinationally
    // on the edge where the level flips, so the pulse register loads on that
    // same edge and the press pulse appears together with the new level.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_debounce
        logic [DB_W-1:0] db_cnt;
        logic            level;
        logic            flip;

        assign flip           = (sync_out[g] != level) && (db_cnt == DB_LAST);
        assign db_level[g]    = level;
        assign press_evt[g]   = flip & ~level;
        assign release_evt[g] = flip & level;

        // Count consecutive disagreeing samples; any agreeing sample restarts.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                db_cnt <= '0;
                level  <= 1'b0;
            end else if (sync_out[g] == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= sync_out[g];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Auto-repeat FSM per direction channel.
    for (genvar g = 0; g < NUM_DIR; g++) begin : g_repeat
        rpt_state_t       state;
        rpt_state_t       state_next;
        logic [RPT_W-1:0] rpt_cnt;
        logic [RPT_W-1:0] rpt_cnt_next;
        logic             pulse;

        // State and repeat counter registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state   <= RPT_IDLE;
                rpt_cnt <= '0;
            end else begin
                state   <= state_next;
                rpt_cnt <= rpt_cnt_next;
            end
        end

        // Next state, counter and pulse; disable and release both abort to idle,
        // so a press seen while disabled is simply lost.
        always_comb begin
            state_next   = state;
            rpt_cnt_next = rpt_cnt;
            pulse        = 1'b0;
            if (!enable || release_evt[g]) begin
                state_next   = RPT_IDLE;
                rpt_cnt_next = '0;
            end else begin
                case (state)
                    RPT_IDLE: begin
                        rpt_cnt_next = '0;
                        if (press_evt[g]) begin
                            pulse      = 1'b1;
                            state_next = RPT_DELAY;
                        end
                    end
                    RPT_DELAY: begin
                        if (rpt_cnt == DELAY_LAST) begin
                            pulse        = 1'b1;
                            rpt_cnt_next = '0;
                            state_next   = RPT_REPEAT;
                        end else begin
                            rpt_cnt_next = rpt_cnt + RPT_W'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (rpt_cnt == RATE_LAST) begin
                            pulse        = 1'b1;
                            rpt_cnt_next = '0;
                        end else begin
                            rpt_cnt_next = rpt_cnt + RPT_W'(1);
                        end
                    end
                    default: begin
                        state_next   = RPT_IDLE;
                        rpt_cnt_next = '0;
                    end
                endcase
            end
        end

        assign pulse_next[g] = pulse;
    end

    // Fire never repeats: one pulse per accepted press.
    assign pulse_next[FIRE_CH] = enable & press_evt[FIRE_CH];

    // Registered single-cycle output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_up    <= 1'b0;
            btn_down  <= 1'b0;
            btn_left  <= 1'b0;
            btn_right <= 1'b0;
            btn_fire  <= 1'b0;
        end else begin
            btn_up    <= pulse_next[0];
            btn_down  <= pulse_next[1];
            btn_left  <= pulse_next[2];
            btn_right <= pulse_next[3];
            btn_fire  <= pulse_next[FIRE_CH];
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios followed by random
// button activity. A reference model derives expected pulses from the raw
// input history and pushes them into a scoreboard queue; a monitor on the
// falling clock edge compares the DUT outputs against the queue.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    typedef struct {
        int         cyc;
        logic [4:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [4:0] raw_drv;
    logic       btn_up, btn_down, btn_left, btn_right, btn_fire;
    logic [4:0] dut_mask;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t       sb_q[$];
    bit   [4:0] raw_hist[$];
    bit   [4:0] s_hist[$];
    bit   [4:0] d_m;
    bit   [3:0] act;
    int         p_edge[4];
    bit   [4:0] exp_now;
    bit   [4:0] s_now, press, rel;
    bit         flip;
    int         dt;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .raw_up   (raw_drv[0]),
        .raw_down (raw_drv[1]),
        .raw_left (raw_drv[2]),
        .raw_right(raw_drv[3]),
        .raw_fire (raw_drv[4]),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_fire (btn_fire)
    );

    assign dut_mask = {btn_fire, btn_right, btn_left, btn_down, btn_up};

    always #5 clk = ~clk;

    // Reference model. The synchronized sample at edge k is the raw level seen
    // two edges earlier; the debounced level flips when the last DB samples all
    // disagree with it. Direction pulses fall at offsets 0, RD, RD+RR, ... from
    // an accepted press while the button stays down and enable stays high.
    always @(posedge clk) begin
        cyc     = cyc + 1;
        exp_now = '0;
        if (reset) begin
            raw_hist.delete();
            s_hist.delete();
            d_m = '0;
            act = '0;
        end else begin
            s_now = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 5'b0;
            raw_hist.push_back(raw_drv);
            s_hist.push_back(s_now);
            if (raw_hist.size() > 4) void'(raw_hist.pop_front());
            if (s_hist.size() > DB + 1) void'(s_hist.pop_front());
            press = '0;
            rel   = '0;
            for (int ch = 0; ch < 5; ch++) begin
                flip = (s_hist.size() >= DB);
                for (int j = 0; j < DB; j++)
                    if (flip && s_hist[s_hist.size()-1-j][ch] == d_m[ch]) flip = 1'b0;
                if (flip) begin
                    if (d_m[ch]) rel[ch] = 1'b1;
                    else         press[ch] = 1'b1;
                    d_m[ch] = ~d_m[ch];
                end
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (!enable || rel[ch]) act[ch] = 1'b0;
                else if (press[ch]) begin
                    act[ch]    = 1'b1;
                    p_edge[ch] = cyc;
                end
                if (act[ch]) begin
                    dt = cyc - p_edge[ch];
                    if (dt == 0 || dt == RD || (dt > RD && (dt - RD) % RR == 0))
                        exp_now[ch] = 1'b1;
                end
            end
            exp_now[4] = press[4] & enable;
            if (exp_now != 5'b0) sb_q.push_back('{cyc: cyc, mask: exp_now});
        end
    end

    // Monitor: compares whenever the DUT shows a pulse or one is expected now.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [4:0] want;
        bit         has;
        want = '0;
        has  = 1'b0;
        while (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL stale_expect cyc=%0d expected mask %b never compared", e.cyc, e.mask);
        end
        if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
            e    = sb_q.pop_front();
            want = e.mask;
            has  = 1'b1;
        end
        if (has || dut_mask != 5'b0) begin
            n_tests++;
            if (dut_mask !== want) begin
                n_fail++;
                $display("FAIL pulse cyc=%0d got=%b exp=%b ({fire,right,left,down,up})",
                         cyc, dut_mask, want);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        int         hold[5];
        int         en_hold;
        int         nd;
        bit         got;
        logic [4:0] rv;

        reset   = 1'b1;
        enable  = 1'b1;
        raw_drv = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (dut_mask !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=00000", dut_mask);
        end
        reset = 1'b0;
        run(3);

        // Single press held 8 cycles: one pulse only.
        raw_drv = 5'b00001;
        run(8);
        raw_drv = '0;
        run(20);

        // Chatter shorter than the debounce window: never a pulse.
        for (int i = 0; i < 20; i++) begin
            raw_drv[2] = (i % 2 == 0);
            run(2);
        end
        raw_drv = '0;
        run(15);

        // Long hold on down: press pulse plus auto-repeat.
        raw_drv = 5'b00010;
        run(30);
        raw_drv = '0;
        run(20);

        // Fire held 50 cycles: exactly one pulse.
        raw_drv = 5'b10000;
        run(50);
        raw_drv = '0;
        run(15);

        // Simultaneous up and right.
        raw_drv = 5'b01001;
        run(12);
        raw_drv = '0;
        run(15);

        // Same press while disabled, then enable while still held.
        enable  = 1'b0;
        raw_drv = 5'b01001;
        run(10);
        enable = 1'b1;
        run(25);
        raw_drv = '0;
        run(15);

        // Reset during auto-repeat with down still held.
        raw_drv = 5'b00010;
        nd  = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (exp_now[1]) nd++;
            if (nd >= 3) got = 1'b1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL reset_mid_repeat_setup timeout waiting for repeat pulse, saw %0d of 3", nd);
        end else begin
            #1;
            reset = 1'b1;
            #1;
            if (dut_mask !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_async_clear got=%b exp=00000", dut_mask);
            end
        end
        run(3);
        reset = 1'b0;
        run(30);
        raw_drv = '0;
        run(20);

        // Random activity on all channels with occasional disable windows.
        rv      = '0;
        en_hold = 40;
        for (int c = 0; c < 5; c++) hold[c] = $urandom_range(1, 20);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            for (int c = 0; c < 5; c++) begin
                if (hold[c] == 0) begin
                    rv[c]   = ~rv[c];
                    hold[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3)
                                                           : $urandom_range(5, 40);
                end else begin
                    hold[c]--;
                end
            end
            raw_drv = rv;
            if (en_hold == 0) begin
                enable  = ($urandom_range(0, 3) != 0);
                en_hold = $urandom_range(10, 60);
            end else begin
                en_hold--;
            end
            if (t == 1500) begin
                #2;
                reset = 1'b1;
                @(negedge clk);
                #2;
                reset = 1'b0;
            end
        end
        raw_drv = '0;
        enable  = 1'b1;
        run(20);

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending entries exp 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
